id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath width.
REQ-002 Parameter ADDR_WIDTH, default 5, register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  external hold (e.g. memory wait); freezes stage contents.
REQ-006 flush  input  1  branch/jump redirect; loads a bubble.
REQ-007 id_valid  input  1  decode slot holds a real instruction.
REQ-008 id_rs1, id_rs2, id_rd  input  ADDR_WIDTH  decoded register indices.
REQ-009 id_rd1, id_rd2, id_imm  input  DATA_WIDTH  register-file reads and sign-extended immediate.
REQ-010 id_ALUsrc  input  1  1 selects id_imm as second operand.
REQ-011 id_ALUctrl  input  3  ALU operation code.
REQ-012 id_RegWrite, id_MemRead  input  1  writeback and load flags.
REQ-013 exmem_rd, memwb_rd  input  ADDR_WIDTH  destinations of the two later stages.
REQ-014 exmem_RegWrite, memwb_RegWrite  input  1  later-stage write enables.
REQ-015 exmem_ALUout, memwb_result  input  DATA_WIDTH  later-stage results.
REQ-016 ALUop1, ALUop2  output  DATA_WIDTH  ALU operands.
REQ-017 ALUctrl  output  3  registered ALU operation code.
REQ-018 ex_rd  output  ADDR_WIDTH; ex_RegWrite, ex_MemRead, ex_valid  output  1  registered control.
REQ-019 ex_store_data  output  DATA_WIDTH  forwarded rs2 value for stores.
REQ-020 hazard_stall  output  1  combinational request to hold PC and IF/ID.

Function
REQ-021 Stage register SHALL capture id_* fields on each edge when not held, not flushed, not hazarded.
REQ-022 Bubble SHALL mean ex_valid=0, ex_RegWrite=0, ex_MemRead=0, ALUctrl=3'b000, ex_rd=0, rs indices 0, data fields 0.
REQ-023 Edge priority SHALL be: rst > flush (bubble) > stall (hold all) > hazard_stall (bubble) > capture.
REQ-024 hazard_stall SHALL assert when id_valid, ex_valid, ex_MemRead, ex_rd!=0, and ex_rd equals id_rs1 or id_rs2 (load-use).
REQ-025 hazard_stall SHALL be masked to 0 while flush is high.
REQ-026 Forwarded rs value SHALL be: exmem_ALUout if exmem_RegWrite, exmem_rd!=0, exmem_rd==rs; else memwb_result if memwb_RegWrite, memwb_rd!=0, memwb_rd==rs; else registered read value.
REQ-027 Index 0 SHALL never be forwarded; its operand SHALL be the registered read value.
REQ-028 ALUop1 SHALL be forwarded rs1; ALUop2 SHALL be registered imm when registered ALUsrc=1, else forwarded rs2.
REQ-029 ex_store_data SHALL always be forwarded rs2, independent of ALUsrc.
REQ-030 Forwarding SHALL be combinational from stage registers and current later-stage inputs; capture-to-ALUop latency one cycle.
REQ-031 A held stage SHALL re-evaluate forwarding every cycle from current later-stage inputs.

Reset
REQ-032 While rst is high at an edge, the stage SHALL load the bubble of REQ-022, regardless of flush/stall.
REQ-033 After reset ALUop1, ALUop2, ex_store_data SHALL read 0 and hazard_stall SHALL be 0.

Configuration
REQ-034 Macro FORWARDING_EN defined: REQ-024 and REQ-026 to REQ-031 apply as written.
REQ-035 FORWARDING_EN undefined: operands SHALL come only from registered reads; hazard_stall SHALL additionally assert for any id_rs (nonzero) matching ex_rd with ex_RegWrite&ex_valid, or exmem_rd with exmem_RegWrite; register file is write-before-read for MEM/WB.

Structure
REQ-036 Shared package cpu_pkg SHALL hold ALU opcode constants, DATA_WIDTH/ADDR_WIDTH defaults, and a packed id_ex_t stage-register typedef with its bubble constant.
REQ-037 Sub-module fwd_mux SHALL implement REQ-026/REQ-027 and be instantiated once per source operand.

Verification
REQ-038 Capture: id_rs1=1,id_rd1=5,id_rd2=7,ALUsrc=0,ctrl=000, no forwards -> next cycle ALUop1=5, ALUop2=7, ALUctrl=000.
REQ-039 Forward priority: rs1=3, exmem_rd=3 ALUout=0xAA, memwb_rd=3 result=0xBB, both RegWrite -> ALUop1=0xAA; drop exmem_RegWrite -> 0xBB.
REQ-040 x0: rs1=0, exmem_rd=0, exmem_RegWrite=1, ALUout=0xFF, id_rd1=0 -> ALUop1=0.
REQ-041 Load-use: ex load to rd=4, id_rs2=4 -> hazard_stall=1 same cycle, next ex_valid=0, following edge captures instruction with memwb forward.
REQ-042 Collisions: flush+stall+hazard same edge -> bubble, hazard_stall=0; stall alone for 3 cycles -> outputs unchanged; rst mid-stall -> bubble.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline widths, ALU opcodes and the ID/EX stage-register layout.
// Contents: DATA_WIDTH/ADDR_WIDTH defaults, ALU_* opcodes, id_ex_t and its bubble ID_EX_BUBBLE.
package cpu_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic                  alu_src;
        logic [2:0]            alu_ctrl;
        logic [ADDR_WIDTH-1:0] rd;
        logic [ADDR_WIDTH-1:0] rs1;
        logic [ADDR_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm;
    } id_ex_t;
    localparam id_ex_t ID_EX_BUBBLE = '0;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: selects one source operand from EX/MEM, MEM/WB or the registered read value.
// Ports: rs (operand index), reg_val (registered read), exmem_*/memwb_* (later-stage
// destination, write enable, result), value (selected operand). EX/MEM wins over MEM/WB;
// index 0 is never forwarded.
module fwd_mux import cpu_pkg::*; #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] reg_val,
    input  logic [ADDR_WIDTH-1:0] exmem_rd,
    input  logic                  exmem_RegWrite,
    input  logic [DATA_WIDTH-1:0] exmem_ALUout,
    input  logic [ADDR_WIDTH-1:0] memwb_rd,
    input  logic                  memwb_RegWrite,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    output logic [DATA_WIDTH-1:0] value
);
    always_comb
        value = (exmem_RegWrite && exmem_rd != '0 && exmem_rd == rs) ? exmem_ALUout :
                (memwb_RegWrite && memwb_rd != '0 && memwb_rd == rs) ? memwb_result : reg_val;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and hazard detection.
// Ports: clk/rst (sync, active-high), stall (hold), flush (bubble), id_* decode fields,
// exmem_*/memwb_* later-stage results, ALUop1/ALUop2/ALUctrl/ex_* stage outputs,
// ex_store_data (rs2 for stores), hazard_stall (combinational hold request).
// Macro FORWARDING_EN: enables EX/MEM and MEM/WB forwarding; when undefined operands come
// from registered reads only and every outstanding RAW dependency stalls instead.
module id_ex_stage import cpu_pkg::*; #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic [DATA_WIDTH-1:0] id_rd1,
    input  logic [DATA_WIDTH-1:0] id_rd2,
    input  logic [DATA_WIDTH-1:0] id_imm,
    input  logic                  id_ALUsrc,
    input  logic [2:0]            id_ALUctrl,
    input  logic                  id_RegWrite,
    input  logic                  id_MemRead,
    input  logic [ADDR_WIDTH-1:0] exmem_rd,
    input  logic [ADDR_WIDTH-1:0] memwb_rd,
    input  logic                  exmem_RegWrite,
    input  logic                  memwb_RegWrite,
    input  logic [DATA_WIDTH-1:0] exmem_ALUout,
    input  logic [DATA_WIDTH-1:0] memwb_result,
    output logic [DATA_WIDTH-1:0] ALUop1,
    output logic [DATA_WIDTH-1:0] ALUop2,
    output logic [2:0]            ALUctrl,
    output logic [ADDR_WIDTH-1:0] ex_rd,
    output logic                  ex_RegWrite,
    output logic                  ex_MemRead,
    output logic                  ex_valid,
    output logic [DATA_WIDTH-1:0] ex_store_data,
    output logic                  hazard_stall
);
    id_ex_t ex;
    logic fwd_en, load_use, raw_hazard;
    logic [DATA_WIDTH-1:0] op1, op2;
    assign load_use = id_valid && ex.valid && ex.mem_read && ex.rd != '0 &&
                      (ex.rd == id_rs1 || ex.rd == id_rs2);
`ifdef FORWARDING_EN
    assign fwd_en     = 1'b1;
    assign raw_hazard = 1'b0;
`else
    // Without bypass paths any producer still in EX or EX/MEM must drain first;
    // MEM/WB is covered by the write-before-read register file.
    assign fwd_en     = 1'b0;
    assign raw_hazard = id_valid && (
        (id_rs1 != '0 && ((ex.valid && ex.reg_write && ex.rd == id_rs1) ||
                          (exmem_RegWrite && exmem_rd == id_rs1))) ||
        (id_rs2 != '0 && ((ex.valid && ex.reg_write && ex.rd == id_rs2) ||
                          (exmem_RegWrite && exmem_rd == id_rs2))));
`endif
    assign hazard_stall = !flush && (load_use || raw_hazard);
    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs1 (
        .rs(ex.rs1), .reg_val(ex.rd1),
        .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite && fwd_en), .exmem_ALUout(exmem_ALUout),
        .memwb_rd(memwb_rd), .memwb_RegWrite(memwb_RegWrite && fwd_en), .memwb_result(memwb_result),
        .value(op1)
    );
    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs2 (
        .rs(ex.rs2), .reg_val(ex.rd2),
        .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_RegWrite && fwd_en), .exmem_ALUout(exmem_ALUout),
        .memwb_rd(memwb_rd), .memwb_RegWrite(memwb_RegWrite && fwd_en), .memwb_result(memwb_result),
        .value(op2)
    );
    always_ff @(posedge clk)
        if (rst || flush)
            ex <= ID_EX_BUBBLE;
        else if (!stall)
            ex <= hazard_stall ? ID_EX_BUBBLE : '{valid: id_valid, reg_write: id_RegWrite,
                  mem_read: id_MemRead, alu_src: id_ALUsrc, alu_ctrl: id_ALUctrl,
                  rd: id_rd, rs1: id_rs1, rs2: id_rs2, rd1: id_rd1, rd2: id_rd2, imm: id_imm};
    assign ALUop1        = op1;
    assign ALUop2        = ex.alu_src ? ex.imm : op2;
    assign ex_store_data = op2;
    assign ALUctrl       = ex.alu_ctrl;
    assign ex_rd         = ex.rd;
    assign ex_RegWrite   = ex.reg_write;
    assign ex_MemRead    = ex.mem_read;
    assign ex_valid      = ex.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a behavioural model.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid, id_ALUsrc, id_RegWrite, id_MemRead;
    logic [4:0]  id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
    logic [31:0] id_rd1, id_rd2, id_imm, exmem_ALUout, memwb_result;
    logic [2:0]  id_ALUctrl, ALUctrl;
    logic        exmem_RegWrite, memwb_RegWrite;
    logic [31:0] ALUop1, ALUop2, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_RegWrite, ex_MemRead, ex_valid, hazard_stall;
    int total = 0, bad = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_ALUsrc(id_ALUsrc), .id_ALUctrl(id_ALUctrl),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_RegWrite(exmem_RegWrite), .memwb_RegWrite(memwb_RegWrite),
        .exmem_ALUout(exmem_ALUout), .memwb_result(memwb_result),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl), .ex_rd(ex_rd),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_valid(ex_valid),
        .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, rw, mr, src;
        logic [2:0]  ctrl;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] a, b, imm;
    } stage_t;
    stage_t m, nxt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] v);
`ifdef FORWARDING_EN
        if (rs != 0 && exmem_RegWrite && exmem_rd == rs) return exmem_ALUout;
        if (rs != 0 && memwb_RegWrite && memwb_rd == rs) return memwb_result;
`endif
        return v;
    endfunction

    function automatic logic depends(input logic [4:0] rs);
        logic hit;
        hit = m.v && m.mr && m.rd != 0 && m.rd == rs;
`ifndef FORWARDING_EN
        hit = hit || (rs != 0 && ((m.v && m.rw && m.rd == rs) || (exmem_RegWrite && exmem_rd == rs)));
`endif
        return hit;
    endfunction

    function automatic logic exp_hz();
        return !flush && id_valid && (depends(id_rs1) || depends(id_rs2));
    endfunction

    task automatic tick();
        @(negedge clk);
        check("valid", ex_valid, m.v);
        check("regwrite", ex_RegWrite, m.rw);
        check("memread", ex_MemRead, m.mr);
        check("ctrl", ALUctrl, m.ctrl);
        check("rd", ex_rd, m.rd);
        check("op1", ALUop1, fwd(m.rs1, m.a));
        check("op2", ALUop2, m.src ? m.imm : fwd(m.rs2, m.b));
        check("store", ex_store_data, fwd(m.rs2, m.b));
        check("hazard", hazard_stall, exp_hz());
        if (rst || flush || (!stall && exp_hz()))
            nxt = '{default: '0};
        else if (stall)
            nxt = m;
        else
            nxt = '{v: id_valid, rw: id_RegWrite, mr: id_MemRead, src: id_ALUsrc, ctrl: id_ALUctrl,
                    rd: id_rd, rs1: id_rs1, rs2: id_rs2, a: id_rd1, b: id_rd2, imm: id_imm};
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic idle();
        {rst, stall, flush, id_valid, id_ALUsrc, id_RegWrite, id_MemRead} = '0;
        {id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd} = '0;
        {id_rd1, id_rd2, id_imm, exmem_ALUout, memwb_result} = '0;
        {id_ALUctrl, exmem_RegWrite, memwb_RegWrite} = '0;
    endtask

    task automatic load_to_r4();
        idle();
        id_valid = 1; id_MemRead = 1; id_RegWrite = 1; id_rd = 4;
        tick();
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        m = '{default: '0};
        #1;
        tick();
        check("rst_op1", ALUop1, 0);
        check("rst_op2", ALUop2, 0);
        check("rst_store", ex_store_data, 0);
        check("rst_hazard", hazard_stall, 0);

        idle();
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 6; id_rd1 = 5; id_rd2 = 7;
        tick();
        check("cap_op1", ALUop1, 5);
        check("cap_op2", ALUop2, 7);
        check("cap_ctrl", ALUctrl, 0);
        check("cap_valid", ex_valid, 1);

        idle();
        id_valid = 1; id_rs1 = 3; id_rd1 = 32'h11;
        tick();
        stall = 1;
        exmem_rd = 3; exmem_RegWrite = 1; exmem_ALUout = 32'hAA;
        memwb_rd = 3; memwb_RegWrite = 1; memwb_result = 32'hBB;
        #1;
`ifdef FORWARDING_EN
        check("fwd_exmem", ALUop1, 32'hAA);
`else
        check("fwd_exmem", ALUop1, 32'h11);
`endif
        exmem_RegWrite = 0;
        #1;
`ifdef FORWARDING_EN
        check("fwd_memwb", ALUop1, 32'hBB);
`else
        check("fwd_memwb", ALUop1, 32'h11);
`endif
        tick();

        idle();
        id_valid = 1; exmem_RegWrite = 1; exmem_ALUout = 32'hFF;
        tick();
        check("x0_op1", ALUop1, 0);

        load_to_r4();
        id_MemRead = 0; id_rs2 = 4; id_rd = 5; id_rd2 = 32'h33;
        #1;
        check("lu_hazard", hazard_stall, 1);
        tick();
        check("lu_bubble", ex_valid, 0);
        memwb_rd = 4; memwb_RegWrite = 1; memwb_result = 32'h44;
        #1;
        check("lu_clear", hazard_stall, 0);
        tick();
        check("lu_valid", ex_valid, 1);
`ifdef FORWARDING_EN
        check("lu_op2", ALUop2, 32'h44);
`else
        check("lu_op2", ALUop2, 32'h33);
`endif

        load_to_r4();
        id_rs1 = 4; flush = 1; stall = 1;
        #1;
        check("col_hazard", hazard_stall, 0);
        tick();
        check("col_valid", ex_valid, 0);
        check("col_rd", ex_rd, 0);

        idle();
        id_valid = 1; id_rs1 = 9; id_rs2 = 10; id_rd = 7; id_rd1 = 32'h55; id_rd2 = 32'h66;
        id_imm = 32'h77; id_ALUsrc = 1; id_ALUctrl = 3'd5; id_RegWrite = 1;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_rd1 = $urandom; id_rd2 = $urandom; id_rd = 5'($urandom_range(0, 31));
            tick();
            check("hold_op1", ALUop1, 32'h55);
            check("hold_op2", ALUop2, 32'h77);
            check("hold_store", ex_store_data, 32'h66);
            check("hold_ctrl", ALUctrl, 5);
        end
        rst = 1;
        tick();
        check("rst_stall_valid", ex_valid, 0);
        check("rst_stall_op2", ALUop2, 0);
        check("rst_stall_store", ex_store_data, 0);

        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 49) == 0;
            flush = $urandom_range(0, 9) == 0;
            stall = $urandom_range(0, 4) == 0;
            id_valid = $urandom_range(0, 4) != 0;
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            exmem_rd = 5'($urandom_range(0, 7));
            memwb_rd = 5'($urandom_range(0, 7));
            id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
            exmem_ALUout = $urandom; memwb_result = $urandom;
            id_ALUsrc = 1'($urandom_range(0, 1));
            id_ALUctrl = 3'($urandom_range(0, 7));
            id_RegWrite = 1'($urandom_range(0, 1));
            id_MemRead = $urandom_range(0, 2) == 0;
            exmem_RegWrite = 1'($urandom_range(0, 1));
            memwb_RegWrite = 1'($urandom_range(0, 1));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
